// File: rtl/ecc_pkg.sv
// Shared definitions for the Montgomery-ladder scalar multiplication sequencer.
package ecc_pkg;

  localparam int unsigned KwDefault      = 163;
  localparam int unsigned TimeoutDefault = 255;

  localparam logic PV_DBL = 1'b0;
  localparam logic PV_ADD = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StScan,
    StInit,
    StAddIss,
    StAddWait,
    StDblIss,
    StDblWait,
    StNext,
    StFin
  } ladder_state_e;

endpackage

// File: rtl/ladder_watchdog.sv
// Per-operation watchdog: cleared on issue, counts wait cycles, flags expiry on the
// wait cycle in which the count reaches Timeout.
module ladder_watchdog #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already elapsed, so the Timeout-th wait
  // cycle is the one that sees Timeout-1.
  assign expire_o = inc_i && (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ladder_seq.sv
// Montgomery-ladder sequencer: scans the scalar for its leading one, then issues an
// add/double point-operation pair for every lower bit.
module ladder_seq
  import ecc_pkg::*;
#(
  parameter int unsigned KW      = KwDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [KW-1:0]         k_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  load_init_o,
  output logic                  pv_in_valid_o,
  output logic                  pv_mode_o,
  output logic                  pv_swap_o,
  input  logic                  pv_done_i,
  output logic [$clog2(KW)-1:0] bit_idx_o
);

  localparam int unsigned IdxW = $clog2(KW);

  ladder_state_e   state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            wd_clr, wd_inc, wd_expire;

  ladder_watchdog #(
    .Timeout (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          k_d     = k_i;
          idx_d   = IdxW'(KW - 1);
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        // idx_q doubles as the recorded leading-one position L once found.
        if (k_q[idx_q]) begin
          state_d = StInit;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StInit: begin
        if (idx_q == '0) begin
          err_d   = 1'b0;
          state_d = StFin;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StAddIss;
        end
      end
      StAddIss: begin
        wd_clr  = 1'b1;
        state_d = StAddWait;
      end
      StAddWait: begin
        wd_inc = 1'b1;
        if (pv_done_i) begin
          state_d = StDblIss;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StDblIss: begin
        wd_clr  = 1'b1;
        state_d = StDblWait;
      end
      StDblWait: begin
        wd_inc = 1'b1;
        if (pv_done_i) begin
          state_d = StNext;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StNext: begin
        if (idx_q == '0) begin
          err_d   = 1'b0;
          state_d = StFin;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StAddIss;
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StFin);
    error_o       = (state_q == StFin) && err_q;
    load_init_o   = (state_q == StInit);
    pv_in_valid_o = (state_q == StAddIss) || (state_q == StDblIss);
    pv_mode_o     = ((state_q == StAddIss) || (state_q == StAddWait)) ? PV_ADD : PV_DBL;
    pv_swap_o     = 1'b0;
    if ((state_q == StAddIss) || (state_q == StAddWait) ||
        (state_q == StDblIss) || (state_q == StDblWait)) begin
      pv_swap_o = k_q[idx_q];
    end
    bit_idx_o     = idx_q;
  end

endmodule
